bcd_countdown_timer: RTL and testbench

Parametrised successor of the microwave mm:ss timer. It provides keypad shift-entry of digits, a built-in one-second prescaler, a "+30 s" quick-add with saturation, and a configurable number of minute digits. It sits between the keypad/control FSM and the 7-segment display driver. It reports zero, running and a one-cycle done pulse to the control FSM.

---
 rtl/timer_pkg.sv | 15 +
 rtl/bcd_down_digit.sv | 58 +++++
 rtl/bcd_countdown_timer.sv | 129 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD count-down timer and its digit cells.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_MAX  = 4'd5;
    localparam bcd_t SEC_TENS_WRAP = 4'd6;

    // A one-tick prescaler still needs a single bit so the compare logic stays uniform.
    function automatic int presc_width(input int ticks);
        return (ticks < 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit cell: shift-load, saturate, add-with-carry and decrement-with-borrow.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter bcd_t MAX = BCD_MAX
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       shift_en,
    input  logic [3:0] shift_in,
    input  logic       sat_en,
    input  logic       add_en,
    input  logic [3:0] add_val,
    input  logic       carry_in,
    input  logic       dec_en,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out,
    output logic       carry_out,
    output logic       is_zero
);

    localparam bcd_t WRAP = (MAX == SEC_TENS_MAX) ? SEC_TENS_WRAP : BCD_MAX + 4'd1;

    logic [3:0] digit_q, digit_d;
    logic [4:0] sum;
    logic [4:0] wrapped;

    // borrow_out means "this digit and every digit below it are zero".
    always_comb begin
        sum        = {1'b0, digit_q} + {1'b0, add_val} + {4'b0000, carry_in};
        wrapped    = sum - {1'b0, WRAP};
        carry_out  = add_en && (sum >= {1'b0, WRAP});
        is_zero    = (digit_q == 4'd0);
        borrow_out = borrow_in && is_zero;
        digit_d    = digit_q;
        if (shift_en) begin
            digit_d = shift_in;
        end else if (sat_en) begin
            digit_d = MAX;
        end else if (add_en) begin
            digit_d = carry_out ? wrapped[3:0] : sum[3:0];
        end else if (dec_en && borrow_in) begin
            digit_d = is_zero ? MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD count-down timer with keypad shift entry, one-second prescaler,
// saturating quick-add and a one-cycle done pulse.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_MIN_DIGITS   = 2,
    parameter int TICKS_PER_SEC    = 100,
    parameter int ADD_SECONDS_TENS = 3
) (
    input  logic                        clk,
    input  logic                        clearn,
    input  logic                        loadn,
    input  logic                        enable,
    input  logic                        add_pulse,
    input  logic [3:0]                  bcd_input,
    output logic [3:0]                  bcd_output_usec,
    output logic [3:0]                  bcd_output_dsec,
    output logic [4*NUM_MIN_DIGITS-1:0] bcd_output_min,
    output logic                        zero,
    output logic                        running,
    output logic                        done
);

    localparam int            PW         = presc_width(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    ADD_VAL    = 4'(ADD_SECONDS_TENS);

    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          tick, shift_en, add_en, dec_en, sat_en;
    logic          usec_borrow, usec_carry, usec_zero, dsec_zero;
    logic [NUM_MIN_DIGITS:0]   min_borrow, min_carry;
    logic [NUM_MIN_DIGITS-1:0] min_zero;

    // Keypress beats quick-add, which beats the one-second tick.
    always_comb begin
        shift_en = !loadn && (bcd_input <= BCD_MAX);
        add_en   = loadn && add_pulse;
        tick     = enable && !zero && (presc_q == PRESC_LAST);
        dec_en   = loadn && !add_pulse && tick;
        sat_en   = add_en && min_carry[NUM_MIN_DIGITS];
        presc_d  = presc_q;
        if (!loadn) begin
            presc_d = shift_en ? '0 : presc_q;
        end else if (zero) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        // Only 0:01 can reach 0:00 on a decrement.
        done_d = dec_en && dsec_zero && (&min_zero) && !usec_zero
                 && (bcd_output_usec[3:1] == 3'b000);
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    bcd_down_digit #(.MAX(BCD_MAX)) u_usec (
        .clk        (clk),
        .clearn     (clearn),
        .shift_en   (shift_en),
        .shift_in   (bcd_input),
        .sat_en     (sat_en),
        .add_en     (add_en),
        .add_val    (4'd0),
        .carry_in   (1'b0),
        .dec_en     (dec_en),
        .borrow_in  (1'b1),
        .digit      (bcd_output_usec),
        .borrow_out (usec_borrow),
        .carry_out  (usec_carry),
        .is_zero    (usec_zero)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_dsec (
        .clk        (clk),
        .clearn     (clearn),
        .shift_en   (shift_en),
        .shift_in   (bcd_output_usec),
        .sat_en     (sat_en),
        .add_en     (add_en),
        .add_val    (ADD_VAL),
        .carry_in   (usec_carry),
        .dec_en     (dec_en),
        .borrow_in  (usec_borrow),
        .digit      (bcd_output_dsec),
        .borrow_out (min_borrow[0]),
        .carry_out  (min_carry[0]),
        .is_zero    (dsec_zero)
    );

    for (genvar i = 0; i < NUM_MIN_DIGITS; i++) begin : g_min
        logic [3:0] shift_src;
        if (i == 0) begin : g_first
            assign shift_src = bcd_output_dsec;
        end else begin : g_rest
            assign shift_src = bcd_output_min[4*(i-1) +: 4];
        end

        bcd_down_digit #(.MAX(BCD_MAX)) u_min (
            .clk        (clk),
            .clearn     (clearn),
            .shift_en   (shift_en),
            .shift_in   (shift_src),
            .sat_en     (sat_en),
            .add_en     (add_en),
            .add_val    (4'd0),
            .carry_in   (min_carry[i]),
            .dec_en     (dec_en),
            .borrow_in  (min_borrow[i]),
            .digit      (bcd_output_min[4*i +: 4]),
            .borrow_out (min_borrow[i+1]),
            .carry_out  (min_carry[i+1]),
            .is_zero    (min_zero[i])
        );
    end

    assign zero    = min_borrow[NUM_MIN_DIGITS];
    assign running = enable && !zero;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Two timers (4 ticks/s and 1 tick/s) driven in lockstep and checked every cycle
// against a digit-arithmetic reference model.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       clearn = 1'b0;
    logic       loadn = 1'b1;
    logic       enable = 1'b0;
    logic       addPulse = 1'b0;
    logic [3:0] bcdIn = 4'd0;

    logic [3:0] usecA, dsecA, usecB, dsecB;
    logic [7:0] minA, minB;
    logic       zeroA, runA, doneA, zeroB, runB, doneB;

    int vectors = 0;
    int miscompares = 0;

    int mMin[2];
    int mDsec[2];
    int mUsec[2];
    int mPresc[2];
    bit mDone[2];
    int ticks[2] = '{4, 1};

    bcd_countdown_timer #(.NUM_MIN_DIGITS(2), .TICKS_PER_SEC(4), .ADD_SECONDS_TENS(3)) dutA (
        .clk(clk), .clearn(clearn), .loadn(loadn), .enable(enable), .add_pulse(addPulse),
        .bcd_input(bcdIn), .bcd_output_usec(usecA), .bcd_output_dsec(dsecA),
        .bcd_output_min(minA), .zero(zeroA), .running(runA), .done(doneA)
    );

    bcd_countdown_timer #(.NUM_MIN_DIGITS(2), .TICKS_PER_SEC(1), .ADD_SECONDS_TENS(3)) dutB (
        .clk(clk), .clearn(clearn), .loadn(loadn), .enable(enable), .add_pulse(addPulse),
        .bcd_input(bcdIn), .bcd_output_usec(usecB), .bcd_output_dsec(dsecB),
        .bcd_output_min(minB), .zero(zeroB), .running(runB), .done(doneB)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit modelZero(input int k);
        return (mMin[k] == 0) && (mDsec[k] == 0) && (mUsec[k] == 0);
    endfunction

    task automatic modelClear();
        for (int k = 0; k < 2; k++) begin
            mMin[k] = 0; mDsec[k] = 0; mUsec[k] = 0; mPresc[k] = 0; mDone[k] = 1'b0;
        end
    endtask

    task automatic modelStep(input int k, input bit ld, input bit en, input bit add, input int din);
        bit zeroNow;
        bit tick;
        int v;
        int s;
        zeroNow = modelZero(k);
        tick = en && !zeroNow && (mPresc[k] == ticks[k] - 1);
        mDone[k] = 1'b0;
        if (!ld) begin
            if (din <= 9) begin
                v = ((mMin[k] * 100 + mDsec[k] * 10 + mUsec[k]) * 10 + din) % 10000;
                mMin[k] = v / 100; mDsec[k] = (v / 10) % 10; mUsec[k] = v % 10;
                mPresc[k] = 0;
            end
        end else begin
            if (add) begin
                s = mDsec[k] + 3;
                if (s >= 6) begin
                    if (mMin[k] == 99) begin
                        mDsec[k] = 5; mUsec[k] = 9;
                    end else begin
                        mDsec[k] = s - 6; mMin[k] = mMin[k] + 1;
                    end
                end else begin
                    mDsec[k] = s;
                end
            end else if (tick) begin
                if (mUsec[k] > 0) mUsec[k] = mUsec[k] - 1;
                else begin
                    mUsec[k] = 9;
                    if (mDsec[k] > 0) mDsec[k] = mDsec[k] - 1;
                    else begin
                        mDsec[k] = 5; mMin[k] = mMin[k] - 1;
                    end
                end
                mDone[k] = modelZero(k);
            end
            if (zeroNow) mPresc[k] = 0;
            else if (en) mPresc[k] = tick ? 0 : mPresc[k] + 1;
        end
    endtask

    task automatic checkVal(input string tag, input int k, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s[dut%0d]: observed %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] disp;
        logic [15:0] expDisp;
        logic        z, r, d;
        for (int k = 0; k < 2; k++) begin
            disp = (k == 0) ? {minA, dsecA, usecA} : {minB, dsecB, usecB};
            z = (k == 0) ? zeroA : zeroB;
            r = (k == 0) ? runA : runB;
            d = (k == 0) ? doneA : doneB;
            expDisp = {4'(mMin[k] / 10), 4'(mMin[k] % 10), 4'(mDsec[k]), 4'(mUsec[k])};
            checkVal("display", k, disp, expDisp);
            checkVal("zero", k, {15'd0, z}, {15'd0, modelZero(k)});
            checkVal("running", k, {15'd0, r}, {15'd0, enable && !modelZero(k)});
            checkVal("done", k, {15'd0, d}, {15'd0, mDone[k]});
        end
    endtask

    task automatic applyStimulus(input bit ld, input bit en, input bit add, input logic [3:0] din);
        loadn = ld; enable = en; addPulse = add; bcdIn = din;
        @(posedge clk);
        for (int k = 0; k < 2; k++) modelStep(k, ld, en, add, int'(din));
        #1;
        checkOutput();
    endtask

    task automatic press(input logic [3:0] din);
        applyStimulus(1'b0, 1'b0, 1'b0, din);
    endtask

    task automatic doClear();
        loadn = 1'b1; enable = 1'b0; addPulse = 1'b0;
        #2 clearn = 1'b0;
        #1 modelClear();
        checkOutput();
        #2 clearn = 1'b1;
    endtask

    initial begin
        #12;
        modelClear();
        checkOutput();
        @(negedge clk);
        clearn = 1'b1;
        @(posedge clk);
        #1;

        // 1:30 counted down at one tick per cycle
        press(4'd1); press(4'd3); press(4'd0);
        checkVal("load130", 1, {minB, dsecB, usecB}, 16'h0130);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t1_129", 1, {minB, dsecB, usecB}, 16'h0129);
        repeat (30) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t1_059", 1, {minB, dsecB, usecB}, 16'h0059);
        repeat (59) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t1_done", 1, {15'd0, doneB}, 16'd1);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t1_hold", 1, {minB, dsecB, usecB}, 16'h0000);

        // 0:90 at four ticks per second
        doClear();
        press(4'd9); press(4'd0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t2_089", 0, {minA, dsecA, usecA}, 16'h0089);
        repeat (36) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t2_080", 0, {minA, dsecA, usecA}, 16'h0080);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t2_079", 0, {minA, dsecA, usecA}, 16'h0079);
        repeat (315) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t2_predone", 0, {15'd0, doneA}, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("t2_done", 0, {15'd0, doneA}, 16'd1);

        // quick-add, saturation and a 6..9 tens digit carrying into minutes
        doClear();
        press(4'd2); press(4'd4); press(4'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        checkVal("add315", 0, {minA, dsecA, usecA}, 16'h0315);
        press(4'd9); press(4'd9); press(4'd5); press(4'd0);
        checkVal("load9950", 0, {minA, dsecA, usecA}, 16'h9950);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        checkVal("sat9959", 0, {minA, dsecA, usecA}, 16'h9959);
        doClear();
        press(4'd9); press(4'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
        checkVal("add160", 0, {minA, dsecA, usecA}, 16'h0160);

        // pause mid-prescale
        doClear();
        press(4'd5);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
        checkVal("pause005", 0, {minA, dsecA, usecA}, 16'h0005);
        repeat (17) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("pause_predone", 0, {15'd0, doneA}, 16'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("pause_done", 0, {15'd0, doneA}, 16'd1);

        // keypress wins over add and tick; invalid digit ignored
        doClear();
        press(4'd9);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd2);
        checkVal("prio092", 0, {minA, dsecA, usecA}, 16'h0092);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hA);
        checkVal("badkey", 0, {minA, dsecA, usecA}, 16'h0092);

        // asynchronous clear mid-count
        doClear();
        press(4'd4); press(4'd2);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkVal("pre_clr", 0, {minA, dsecA, usecA}, 16'h0042);
        #3 clearn = 1'b0;
        #1 modelClear();
        checkOutput();
        checkVal("async_clr", 0, {minA, dsecA, usecA, 3'd0, zeroA} == {16'h0000, 4'd1} ? 16'd1 : 16'd0, 16'd1);
        #2 clearn = 1'b1;
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);

        // randomized traffic
        doClear();
        repeat (400) begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
